// File: rtl/id_scoreboard.sv
// Register-hazard scoreboard beside decode: per-register pending-write counters,
// decode stall, flush handling and a stall watchdog. Optional macro SCOREBOARD_BYPASS_EN.
module id_scoreboard #(
  parameter int REG_NUM     = 32,
  parameter int CNT_W       = 2,
  parameter int STALL_LIMIT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue_valid_i,
  input  logic       reg1_read_i,
  input  logic [4:0] reg1_addr_i,
  input  logic       reg2_read_i,
  input  logic [4:0] reg2_addr_i,
  input  logic       wreg_i,
  input  logic [4:0] wd_i,
  input  logic       wb_we_i,
  input  logic [4:0] wb_addr_i,
  input  logic       flush_i,
  output logic       stall_o,
  output logic       issue_fire_o,
  output logic       busy_o,
  output logic       err_o,
  output logic       timeout_o
);
  localparam int AW = 5;
  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [SW-1:0]    LIMIT   = SW'(STALL_LIMIT);

  typedef enum logic [1:0] {IDLE, TRACK, FLUSH} state_e;

  logic [REG_NUM-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [REG_NUM-1:0]            inc_v, dec_v;
  state_e                        state_q, state_d;
  logic                          err_q, err_d;
  logic [SW-1:0]                 stall_cnt_q, stall_cnt_d;
  logic                          src1_haz, src2_haz, dst_haz;

  always_comb begin
    src1_haz = reg1_read_i & (cnt_q[reg1_addr_i] != '0);
    src2_haz = reg2_read_i & (cnt_q[reg2_addr_i] != '0);
`ifdef SCOREBOARD_BYPASS_EN
    // Last outstanding write retiring now: forwarding supplies the operand.
    if (wb_we_i && wb_addr_i == reg1_addr_i && cnt_q[reg1_addr_i] == CNT_ONE) src1_haz = 1'b0;
    if (wb_we_i && wb_addr_i == reg2_addr_i && cnt_q[reg2_addr_i] == CNT_ONE) src2_haz = 1'b0;
`endif
    dst_haz = wreg_i & (wd_i != '0) & (cnt_q[wd_i] == CNT_MAX);
  end

  assign stall_o      = rst & issue_valid_i & ~flush_i & (src1_haz | src2_haz | dst_haz);
  assign issue_fire_o = rst & issue_valid_i & ~stall_o & ~flush_i & (state_q != FLUSH);

  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int r = 1; r < REG_NUM; r++) begin
      inc_v[r] = issue_fire_o & wreg_i & (wd_i == AW'(r));
      dec_v[r] = wb_we_i & (wb_addr_i == AW'(r)) & (cnt_q[r] != '0);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (flush_i) begin
      cnt_d = '0;
    end else begin
      for (int r = 1; r < REG_NUM; r++) begin
        if (inc_v[r] && !dec_v[r])      cnt_d[r] = cnt_q[r] + CNT_ONE;
        else if (dec_v[r] && !inc_v[r]) cnt_d[r] = cnt_q[r] - CNT_ONE;
      end
    end
    cnt_d[0] = '0;
  end

  // Writebacks to r0 are legal (rd=0 instructions), so they never flag.
  assign err_d = err_q | (wb_we_i & ~flush_i & (wb_addr_i != '0) & (cnt_q[wb_addr_i] == '0));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|cnt_d) state_d = TRACK;
      TRACK:   if (flush_i) state_d = FLUSH;
               else if (!(|cnt_d)) state_d = IDLE;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_cnt_d = '0;
    if (stall_o && !flush_i)
      stall_cnt_d = (stall_cnt_q >= LIMIT) ? stall_cnt_q : stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      state_q     <= IDLE;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign busy_o    = (state_q != IDLE);
  assign err_o     = err_q;
  assign timeout_o = (stall_cnt_q >= LIMIT);
endmodule

// File: tb/tb_id_scoreboard.sv
// Directed scenarios for id_scoreboard; expected values are hand-derived per scenario.
module tb_id_scoreboard;
  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid_i, reg1_read_i, reg2_read_i, wreg_i, wb_we_i, flush_i;
  logic [4:0] reg1_addr_i, reg2_addr_i, wd_i, wb_addr_i;
  logic       stall_o, issue_fire_o, busy_o, err_o, timeout_o;
  int         errors = 0;
  int         checks = 0;

`ifdef SCOREBOARD_BYPASS_EN
  localparam logic BYP_STALL = 1'b0;
`else
  localparam logic BYP_STALL = 1'b1;
`endif

  id_scoreboard #(.REG_NUM(32), .CNT_W(2), .STALL_LIMIT(64)) dut (
    .clk(clk), .rst(rst), .issue_valid_i(issue_valid_i),
    .reg1_read_i(reg1_read_i), .reg1_addr_i(reg1_addr_i),
    .reg2_read_i(reg2_read_i), .reg2_addr_i(reg2_addr_i),
    .wreg_i(wreg_i), .wd_i(wd_i), .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i),
    .flush_i(flush_i), .stall_o(stall_o), .issue_fire_o(issue_fire_o),
    .busy_o(busy_o), .err_o(err_o), .timeout_o(timeout_o));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic quiet;
    issue_valid_i = 0; reg1_read_i = 0; reg2_read_i = 0; wreg_i = 0; wb_we_i = 0; flush_i = 0;
    reg1_addr_i = 0; reg2_addr_i = 0; wd_i = 0; wb_addr_i = 0;
  endtask

  task automatic issue_wr(input logic [4:0] d);
    quiet(); issue_valid_i = 1; wreg_i = 1; wd_i = d;
  endtask

  task automatic issue_rd(input logic [4:0] a);
    quiet(); issue_valid_i = 1; reg1_read_i = 1; reg1_addr_i = a;
  endtask

  task automatic wb(input logic [4:0] a);
    quiet(); wb_we_i = 1; wb_addr_i = a;
  endtask

  task automatic test_reset;
    rst = 0; quiet(); #1;
    checks++; if ({stall_o, issue_fire_o, busy_o, err_o, timeout_o} !== 5'b0) begin errors++; $display("FAIL reset_outs: got %b want 00000", {stall_o, issue_fire_o, busy_o, err_o, timeout_o}); end
    tick(); rst = 1; tick();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
  endtask

  task automatic test_raw;
    issue_wr(5); #1;
    checks++; if (issue_fire_o !== 1'b1) begin errors++; $display("FAIL raw_issue_fire: got %b want 1", issue_fire_o); end
    tick();
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL raw_busy: got %b want 1", busy_o); end
    issue_rd(5); #1;
    checks++; if ({stall_o, issue_fire_o} !== 2'b10) begin errors++; $display("FAIL raw_stall: got %b want 10", {stall_o, issue_fire_o}); end
    tick();
    wb_we_i = 1; wb_addr_i = 5; #1;
    checks++; if (stall_o !== BYP_STALL) begin errors++; $display("FAIL raw_wb_same_cycle: got %b want %b", stall_o, BYP_STALL); end
    tick();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL raw_busy_clear: got %b want 0", busy_o); end
    wb_we_i = 0; #1;
    checks++; if ({stall_o, issue_fire_o} !== 2'b01) begin errors++; $display("FAIL raw_unblocked: got %b want 01", {stall_o, issue_fire_o}); end
    tick(); quiet();
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 3; i++) begin issue_wr(7); tick(); end
    issue_wr(7); #1;
    checks++; if ({stall_o, issue_fire_o} !== 2'b10) begin errors++; $display("FAIL ovf_stall_at_3: got %b want 10", {stall_o, issue_fire_o}); end
    wb(7); tick();                       // 3 -> 2
    issue_wr(7); wb_we_i = 1; wb_addr_i = 7; #1;
    checks++; if ({stall_o, issue_fire_o} !== 2'b01) begin errors++; $display("FAIL ovf_inc_dec_fire: got %b want 01", {stall_o, issue_fire_o}); end
    tick();                              // inc & dec: stays 2
    issue_wr(7); #1;
    checks++; if (issue_fire_o !== 1'b1) begin errors++; $display("FAIL ovf_refill: got %b want 1", issue_fire_o); end
    tick();                              // 2 -> 3
    issue_wr(7); #1;
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL ovf_stall_again: got %b want 1", stall_o); end
    wb(7); tick(); wb(7); tick();        // 3 -> 1
    issue_rd(7); #1;
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL ovf_one_left: got %b want 1", stall_o); end
    wb(7); tick();
    issue_rd(7); #1;
    checks++; if ({stall_o, busy_o} !== 2'b00) begin errors++; $display("FAIL ovf_drained: got %b want 00", {stall_o, busy_o}); end
    tick(); quiet();
  endtask

  task automatic test_zero;
    issue_wr(0); #1;
    checks++; if (issue_fire_o !== 1'b1) begin errors++; $display("FAIL zero_issue: got %b want 1", issue_fire_o); end
    tick();
    quiet(); issue_valid_i = 1; reg1_read_i = 1; reg2_read_i = 1; #1;
    checks++; if ({stall_o, busy_o} !== 2'b00) begin errors++; $display("FAIL zero_read: got %b want 00", {stall_o, busy_o}); end
    tick(); quiet();
  endtask

  task automatic test_err;
    wb(9); #1;
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_before_edge: got %b want 0", err_o); end
    tick();
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", err_o); end
    issue_wr(9); tick(); wb(9); tick(); quiet(); tick();
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err_o); end
    rst = 0; #1;
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_reset: got %b want 0", err_o); end
    tick(); rst = 1; tick();
  endtask

  task automatic test_flush;
    issue_wr(3); tick(); issue_wr(4); tick();
    issue_wr(5); flush_i = 1; #1;
    checks++; if ({stall_o, issue_fire_o, busy_o} !== 3'b001) begin errors++; $display("FAIL flush_cycle: got %b want 001", {stall_o, issue_fire_o, busy_o}); end
    tick();
    quiet(); issue_valid_i = 1; reg1_read_i = 1; reg1_addr_i = 3; reg2_read_i = 1; reg2_addr_i = 4; #1;
    checks++; if ({stall_o, issue_fire_o, busy_o} !== 3'b001) begin errors++; $display("FAIL flush_state: got %b want 001", {stall_o, issue_fire_o, busy_o}); end
    tick();
    reg2_addr_i = 5; #1;
    checks++; if ({stall_o, issue_fire_o, busy_o} !== 3'b010) begin errors++; $display("FAIL flush_idle: got %b want 010", {stall_o, issue_fire_o, busy_o}); end
    tick(); quiet();
  endtask

  task automatic test_watchdog;
    issue_wr(12); tick();
    issue_rd(12); #1;
    checks++; if ({stall_o, timeout_o} !== 2'b10) begin errors++; $display("FAIL wd_start: got %b want 10", {stall_o, timeout_o}); end
    for (int i = 0; i < 63; i++) tick();
    checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL wd_63: got %b want 0", timeout_o); end
    tick();
    checks++; if (timeout_o !== 1'b1) begin errors++; $display("FAIL wd_64: got %b want 1", timeout_o); end
    tick(); tick();
    checks++; if (timeout_o !== 1'b1) begin errors++; $display("FAIL wd_saturate: got %b want 1", timeout_o); end
    #2 rst = 0; #1;
    checks++; if ({stall_o, issue_fire_o, busy_o, err_o, timeout_o} !== 5'b0) begin errors++; $display("FAIL wd_async_reset: got %b want 00000", {stall_o, issue_fire_o, busy_o, err_o, timeout_o}); end
    tick(); rst = 1; #1;
    checks++; if ({stall_o, issue_fire_o} !== 2'b01) begin errors++; $display("FAIL wd_after_reset: got %b want 01", {stall_o, issue_fire_o}); end
    tick(); quiet();
  endtask

  initial begin
    test_reset();
    test_raw();
    test_overflow();
    test_zero();
    test_err();
    test_flush();
    test_watchdog();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
